// File: rtl/load_align_unit.sv
// Sequential load unit between the memory stage and write-back: issues one or two
// aligned word reads, then extracts and sign/zero-extends the addressed bytes.
module load_align_unit #(
   parameter int XLEN             = 64,
   parameter int ADDR_W           = 64,
   parameter bit ALLOW_MISALIGNED = 1'b1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [2:0]        req_funct3,
   output logic              mem_rd_en,
   output logic [ADDR_W-1:0] mem_addr,
   input  logic [XLEN-1:0]   mem_rdata,
   output logic              resp_valid,
   input  logic              resp_ready,
   output logic [XLEN-1:0]   resp_data,
   output logic              resp_err
);

   localparam int OFF_W = $clog2(XLEN/8);
   localparam logic [ADDR_W-1:0] STEP = ADDR_W'(XLEN/8);

   localparam logic [2:0] IDLE = 3'd0;
   localparam logic [2:0] RD0  = 3'd1;
   localparam logic [2:0] CAP0 = 3'd2;
   localparam logic [2:0] RD1  = 3'd3;
   localparam logic [2:0] CAP1 = 3'd4;
   localparam logic [2:0] DONE = 3'd5;

   logic [2:0]        state_r;
   logic [2:0]        next_state_s;
   logic [ADDR_W-1:0] addr_r;
   logic [2:0]        funct3_r;
   logic [XLEN-1:0]   lo_r;
   logic [XLEN-1:0]   hi_r;
   logic              req_ready_r;
   logic              mem_rd_en_r;
   logic [ADDR_W-1:0] mem_addr_r;
   logic              resp_valid_r;
   logic [XLEN-1:0]   resp_data_r;
   logic              resp_err_r;

   logic [ADDR_W-1:0] dec_addr_s;
   logic [2:0]        dec_f3_s;
   logic [OFF_W-1:0]  off_s;
   logic [ADDR_W-1:0] base_s;
   logic [3:0]        size_s;
   logic [4:0]        end_s;
   logic              split_s;
   logic              invalid_s;
   logic              err_s;
   logic              accept_s;
   logic [2*XLEN-1:0] window_s;
   logic [XLEN-1:0]   field_s;
   logic [XLEN-1:0]   mask_s;
   logic              sign_s;
   logic [XLEN-1:0]   ext_s;

   // In IDLE the incoming request is decoded; afterwards the latched copy is.
   always_comb begin
      dec_addr_s = (state_r == IDLE) ? req_addr   : addr_r;
      dec_f3_s   = (state_r == IDLE) ? req_funct3 : funct3_r;
      off_s      = dec_addr_s[OFF_W-1:0];
      base_s     = dec_addr_s & ~ADDR_W'(XLEN/8 - 1);
      case (dec_f3_s[1:0])
         2'b00:   size_s = 4'd1;
         2'b01:   size_s = 4'd2;
         2'b10:   size_s = 4'd4;
         default: size_s = 4'd8;
      endcase
      end_s     = 5'(off_s) + 5'(size_s);
      split_s   = (end_s > 5'(XLEN/8));
      invalid_s = (dec_f3_s == 3'b111) ||
                  ((XLEN == 32) && ((dec_f3_s == 3'b011) || (dec_f3_s == 3'b110)));
      err_s     = invalid_s || (split_s && !ALLOW_MISALIGNED);
      accept_s  = req_valid && req_ready_r && (state_r == IDLE);
   end

   // The word arriving this cycle forms one half of the window, the latched word the other.
   always_comb begin
      window_s = (state_r == CAP1) ? {mem_rdata, lo_r} : {hi_r, mem_rdata};
      field_s  = window_s[{off_s, 3'b000} +: XLEN];
      mask_s   = ~({XLEN{1'b1}} << {size_s, 3'b000});
      case (size_s)
         4'd1:    sign_s = field_s[7];
         4'd2:    sign_s = field_s[15];
         4'd4:    sign_s = field_s[31];
         default: sign_s = field_s[XLEN-1];
      endcase
      if (!dec_f3_s[2] && sign_s) begin
         ext_s = (field_s & mask_s) | ~mask_s;
      end else begin
         ext_s = field_s & mask_s;
      end
   end

   // Next-state logic of the load sequencer.
   always_comb begin
      next_state_s = state_r;
      case (state_r)
         IDLE: begin
            if (accept_s) begin
               next_state_s = err_s ? DONE : RD0;
            end else begin
               next_state_s = IDLE;
            end
         end
         RD0:     next_state_s = CAP0;
         CAP0:    next_state_s = split_s ? RD1 : DONE;
         RD1:     next_state_s = CAP1;
         CAP1:    next_state_s = DONE;
         DONE: begin
            if (resp_ready) begin
               next_state_s = IDLE;
            end else begin
               next_state_s = DONE;
            end
         end
         default: next_state_s = IDLE;
      endcase
   end

   // State, request latches and outputs registered from the next state.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r      <= IDLE;
         addr_r       <= '0;
         funct3_r     <= 3'd0;
         lo_r         <= '0;
         hi_r         <= '0;
         req_ready_r  <= 1'b1;
         mem_rd_en_r  <= 1'b0;
         mem_addr_r   <= '0;
         resp_valid_r <= 1'b0;
         resp_data_r  <= '0;
         resp_err_r   <= 1'b0;
      end else begin
         state_r      <= next_state_s;
         req_ready_r  <= (next_state_s == IDLE);
         mem_rd_en_r  <= (next_state_s == RD0) || (next_state_s == RD1);
         resp_valid_r <= (next_state_s == DONE);
         if (next_state_s == RD0) begin
            mem_addr_r <= base_s;
         end else if (next_state_s == RD1) begin
            mem_addr_r <= base_s + STEP;
         end else begin
            mem_addr_r <= '0;
         end
         if (accept_s) begin
            addr_r   <= req_addr;
            funct3_r <= req_funct3;
            lo_r     <= '0;
            hi_r     <= '0;
         end else if (state_r == CAP0) begin
            lo_r <= mem_rdata;
         end else if (state_r == CAP1) begin
            hi_r <= mem_rdata;
         end else begin
            lo_r <= lo_r;
         end
         // The result is frozen on entry to DONE so it stays stable under backpressure.
         if ((next_state_s == DONE) && (state_r != DONE)) begin
            resp_err_r  <= err_s;
            resp_data_r <= err_s ? '0 : ext_s;
         end else begin
            resp_err_r  <= resp_err_r;
         end
      end
   end

   assign req_ready  = req_ready_r;
   assign mem_rd_en  = mem_rd_en_r;
   assign mem_addr   = mem_addr_r;
   assign resp_valid = resp_valid_r;
   assign resp_data  = resp_data_r;
   assign resp_err   = resp_err_r;

endmodule

// File: tb/tb_load_align_unit.sv
// Self-checking bench for load_align_unit: directed table, reset abort, a
// no-misalign instance and randomized loads against a byte-level memory model.
module tb_load_align_unit;

   logic        clk = 1'b0;
   logic        reset;
   logic        req_valid, req_ready;
   logic [63:0] req_addr;
   logic [2:0]  req_funct3;
   logic        mem_rd_en;
   logic [63:0] mem_addr;
   logic [63:0] mem_rdata;
   logic        resp_valid, resp_ready, resp_err;
   logic [63:0] resp_data;

   logic        d1_req_valid, d1_req_ready, d1_mem_rd_en, d1_resp_valid, d1_resp_ready, d1_resp_err;
   logic [63:0] d1_req_addr, d1_mem_addr, d1_resp_data;
   logic [2:0]  d1_req_funct3;
   logic [63:0] d1_mem_rdata = 64'd0;

   int n_tests = 0;
   int n_fail  = 0;
   int d1_reads = 0;
   logic [63:0] rd_q[$];

   always #5 clk = ~clk;

   load_align_unit #(.XLEN(64), .ADDR_W(64), .ALLOW_MISALIGNED(1'b1)) dut (
      .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
      .req_addr(req_addr), .req_funct3(req_funct3), .mem_rd_en(mem_rd_en),
      .mem_addr(mem_addr), .mem_rdata(mem_rdata), .resp_valid(resp_valid),
      .resp_ready(resp_ready), .resp_data(resp_data), .resp_err(resp_err));

   load_align_unit #(.XLEN(64), .ADDR_W(64), .ALLOW_MISALIGNED(1'b0)) dut_nomis (
      .clk(clk), .reset(reset), .req_valid(d1_req_valid), .req_ready(d1_req_ready),
      .req_addr(d1_req_addr), .req_funct3(d1_req_funct3), .mem_rd_en(d1_mem_rd_en),
      .mem_addr(d1_mem_addr), .mem_rdata(d1_mem_rdata), .resp_valid(d1_resp_valid),
      .resp_ready(d1_resp_ready), .resp_data(d1_resp_data), .resp_err(d1_resp_err));

   function automatic logic [63:0] mem_word(input logic [63:0] a);
      if (a == 64'h100) return 64'h8877665544332211;
      if (a == 64'h108) return 64'hFFEEDDCCBBAA9988;
      return {a[31:0] ^ 32'h5A5A1234, a[31:0] * 32'h9E3779B9};
   endfunction

   // Memory answers one cycle after each read strobe and logs the address.
   always @(posedge clk) begin
      if (mem_rd_en) begin
         mem_rdata <= mem_word(mem_addr);
         rd_q.push_back(mem_addr);
      end
      if (d1_mem_rd_en) d1_reads <= d1_reads + 1;
   end

   // Reference: gather the bytes one by one from memory, then extend.
   function automatic logic [63:0] model(input logic [63:0] a, input logic [2:0] f3);
      int size;
      logic [63:0] v, w, ba;
      size = 1 << f3[1:0];
      v = 64'd0;
      for (int i = 0; i < size; i++) begin
         ba = a + 64'(i);
         w  = mem_word(ba & ~64'h7) >> (8 * int'(ba[2:0]));
         v  = v | ((w & 64'hFF) << (8 * i));
      end
      if (!f3[2] && size < 8 && v[size*8-1]) v = v | (~64'd0 << (size * 8));
      return v;
   endfunction

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, got, exp);
      end
   endtask

   task automatic run_load(input string tag, input logic [63:0] a, input logic [2:0] f3,
                           input int stall, input logic [63:0] exp_data, input logic exp_err,
                           input int exp_lat);
      logic [63:0] base;
      int lat, nrd;
      bit split;
      base  = a & ~64'h7;
      split = (64'(a[2:0]) + (64'd1 << f3[1:0])) > 64'd8;
      nrd   = exp_err ? 0 : (split ? 2 : 1);
      rd_q.delete();
      check({tag, ":req_ready_idle"}, 64'(req_ready), 64'd1);
      req_addr = a; req_funct3 = f3; req_valid = 1'b1; resp_ready = 1'b0;
      @(posedge clk); #1;
      req_valid = 1'b0;
      lat = 1;
      while (!resp_valid && lat < 20) begin
         check({tag, ":req_ready_busy"}, 64'(req_ready), 64'd0);
         @(posedge clk); #1;
         lat++;
      end
      check({tag, ":latency"}, 64'(lat), 64'(exp_lat));
      check({tag, ":data"}, resp_data, exp_data);
      check({tag, ":err"}, 64'(resp_err), 64'(exp_err));
      for (int i = 0; i < stall; i++) begin
         @(posedge clk); #1;
         check({tag, ":hold_valid"}, 64'(resp_valid), 64'd1);
         check({tag, ":hold_data"}, resp_data, exp_data);
         check({tag, ":hold_ready"}, 64'(req_ready), 64'd0);
      end
      resp_ready = 1'b1;
      @(posedge clk); #1;
      resp_ready = 1'b0;
      check({tag, ":valid_drop"}, 64'(resp_valid), 64'd0);
      check({tag, ":ready_back"}, 64'(req_ready), 64'd1);
      check({tag, ":nreads"}, 64'(rd_q.size()), 64'(nrd));
      for (int k = 0; k < nrd; k++)
         check({tag, ":rd_addr"}, (k < rd_q.size()) ? rd_q[k] : 64'hDEAD, base + 64'(8 * k));
   endtask

   typedef struct {
      string       name;
      logic [63:0] addr;
      logic [2:0]  f3;
      int          stall;
      logic [63:0] data;
      logic        err;
      int          lat;
   } vec_t;

   vec_t vecs[9];

   initial begin
      vecs[0] = '{"lb_107",   64'h107, 3'b000, 0, 64'hFFFFFFFFFFFFFF88, 1'b0, 3};
      vecs[1] = '{"lhu_106",  64'h106, 3'b101, 0, 64'h0000000000008877, 1'b0, 3};
      vecs[2] = '{"lw_split", 64'h106, 3'b010, 0, 64'hFFFFFFFF99888877, 1'b0, 5};
      vecs[3] = '{"f3_111",   64'h100, 3'b111, 0, 64'h0000000000000000, 1'b1, 1};
      vecs[4] = '{"ld_stall", 64'h100, 3'b011, 3, 64'h8877665544332211, 1'b0, 3};
      vecs[5] = '{"lbu_108",  64'h108, 3'b100, 0, 64'h0000000000000088, 1'b0, 3};
      vecs[6] = '{"lwu_10c",  64'h10C, 3'b110, 0, 64'h00000000FFEEDDCC, 1'b0, 3};
      vecs[7] = '{"lh_10e",   64'h10E, 3'b001, 0, 64'hFFFFFFFFFFFFFFEE, 1'b0, 3};
      vecs[8] = '{"ld_split", 64'h104, 3'b011, 1, 64'hBBAA998888776655, 1'b0, 5};

      reset = 1'b1; req_valid = 1'b0; resp_ready = 1'b0; req_addr = 64'd0; req_funct3 = 3'd0;
      d1_req_valid = 1'b0; d1_resp_ready = 1'b0; d1_req_addr = 64'd0; d1_req_funct3 = 3'd0;
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
      check("rst:req_ready", 64'(req_ready), 64'd1);
      check("rst:mem_rd_en", 64'(mem_rd_en), 64'd0);
      check("rst:resp_valid", 64'(resp_valid), 64'd0);
      check("rst:resp_err", 64'(resp_err), 64'd0);
      check("rst:resp_data", resp_data, 64'd0);

      for (int i = 0; i < 9; i++)
         run_load(vecs[i].name, vecs[i].addr, vecs[i].f3, vecs[i].stall,
                  vecs[i].data, vecs[i].err, vecs[i].lat);

      // Reset pulsed while a split lw sits in CAP0.
      req_addr = 64'h106; req_funct3 = 3'b010; req_valid = 1'b1;
      @(posedge clk); #1 req_valid = 1'b0;
      @(posedge clk); #1 reset = 1'b1;
      @(posedge clk); #1 reset = 1'b0;
      check("abort:mem_rd_en", 64'(mem_rd_en), 64'd0);
      check("abort:req_ready", 64'(req_ready), 64'd1);
      for (int i = 0; i < 6; i++) begin
         check("abort:no_resp", 64'(resp_valid), 64'd0);
         check("abort:no_read", 64'(mem_rd_en), 64'd0);
         @(posedge clk); #1;
      end
      run_load("after_abort_lbu", 64'h108, 3'b100, 0, 64'h88, 1'b0, 3);

      // Split access on the instance that forbids misalignment.
      d1_req_addr = 64'h106; d1_req_funct3 = 3'b010; d1_req_valid = 1'b1;
      @(posedge clk); #1 d1_req_valid = 1'b0;
      check("nomis:valid", 64'(d1_resp_valid), 64'd1);
      check("nomis:err", 64'(d1_resp_err), 64'd1);
      check("nomis:data", d1_resp_data, 64'd0);
      check("nomis:mem_addr", d1_mem_addr, 64'd0);
      d1_resp_ready = 1'b1;
      @(posedge clk); #1 d1_resp_ready = 1'b0;
      check("nomis:valid_drop", 64'(d1_resp_valid), 64'd0);
      check("nomis:ready_back", 64'(d1_req_ready), 64'd1);
      check("nomis:no_reads", 64'(d1_reads), 64'd0);

      // Randomized loads, including accesses that wrap the top of the address space.
      for (int n = 0; n < 150; n++) begin
         logic [63:0] a;
         logic [2:0]  f3;
         bit split, err;
         int st;
         a  = ($urandom_range(0, 3) == 0) ? (64'hFFFFFFFFFFFFFFF0 + 64'($urandom_range(0, 15)))
                                          : (64'h100 + 64'($urandom_range(0, 31)));
         f3 = 3'($urandom_range(0, 7));
         st = $urandom_range(0, 2);
         split = (64'(a[2:0]) + (64'd1 << f3[1:0])) > 64'd8;
         err   = (f3 == 3'b111);
         run_load("rand", a, f3, st, err ? 64'd0 : model(a, f3), err,
                  err ? 1 : (split ? 5 : 3));
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
